// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, shift-add multiply and restoring divide on operand magnitudes.
module muldiv_unit #(
    parameter int nb_bits = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [2:0]         funct3_i,
    input  logic [nb_bits-1:0] rs1_data_i,
    input  logic [nb_bits-1:0] rs2_data_i,
    input  logic [4:0]         rd_add_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [nb_bits-1:0] result_o,
    output logic [4:0]         rd_add_o
);
    localparam int cw = $clog2(nb_bits + 1);
    localparam logic [nb_bits-1:0] min_neg = {1'b1, {(nb_bits-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] op;
    logic [nb_bits-1:0] hi, lo, b, nh, nl, a_mag, b_mag, sp_res, quo, rem, res;
    logic [4:0] rd_q;
    logic [cw-1:0] cnt;
    logic neg_a, neg_b, a_sg, b_sg, na, nb, b_zero, ovf, special, ge;
    logic [nb_bits:0] sum, trial;
    logic [2*nb_bits-1:0] prod, prod_s;
    always_comb begin
        a_sg = ~(funct3_i[0] & (funct3_i[1] | funct3_i[2]));
        b_sg = funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1];
        na = a_sg & rs1_data_i[nb_bits-1];
        nb = b_sg & rs2_data_i[nb_bits-1];
        a_mag = na ? -rs1_data_i : rs1_data_i;
        b_mag = nb ? -rs2_data_i : rs2_data_i;
        b_zero = rs2_data_i == '0;
        ovf = ~funct3_i[0] & (rs1_data_i == min_neg) & (&rs2_data_i);
        special = funct3_i[2] & (b_zero | ovf);
        sp_res = funct3_i[1] ? (b_zero ? rs1_data_i : '0) : (b_zero ? '1 : min_neg);
    end
    // hi:lo holds partial product (multiply) or remainder:dividend (divide)
    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        trial = {hi, lo[nb_bits-1]};
        ge = trial >= {1'b0, b};
        nh = op[2] ? (ge ? trial[nb_bits-1:0] - b : trial[nb_bits-1:0]) : sum[nb_bits:1];
        nl = op[2] ? {lo[nb_bits-2:0], ge} : {sum[0], lo[nb_bits-1:1]};
        prod = {nh, nl};
        prod_s = (neg_a ^ neg_b) ? -prod : prod;
        quo = (neg_a ^ neg_b) ? -nl : nl;
        rem = neg_a ? -nh : nh;
        res = op[2] ? (op[1] ? rem : quo)
                    : (op[1:0] == 2'b00 ? prod_s[nb_bits-1:0] : prod_s[2*nb_bits-1:nb_bits]);
    end
    always_ff @(posedge clk_i) begin
        state <= rst_i ? IDLE : state_nx;
    end
    always_comb begin
        state_nx = state == IDLE ? (start_i ? (special ? DONE : CALC) : IDLE)
                 : state == CALC ? (cnt == cw'(1) ? DONE : CALC) : IDLE;
        busy_o = state != IDLE;
        done_o = state == DONE;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
            result_o <= '0;
            rd_add_o <= '0;
        end else if (state == IDLE && start_i) begin
            op <= funct3_i;
            hi <= '0;
            lo <= a_mag;
            b <= b_mag;
            neg_a <= na;
            neg_b <= nb;
            rd_q <= rd_add_i;
            cnt <= special ? '0 : cw'(nb_bits);
            if (special) begin
                result_o <= sp_res;
                rd_add_o <= rd_add_i;
            end
        end else if (state == CALC) begin
            hi <= nh;
            lo <= nl;
            cnt <= cnt - cw'(1);
            if (cnt == cw'(1)) begin
                result_o <= res;
                rd_add_o <= rd_q;
            end
        end
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter nb_bits, default 32, giving the operand/result width; it SHALL support nb_bits >= 4 and even.
REQ-002 The block SHALL have these ports:
- clk_i  input  1  sole clock; all state changes on its rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request to begin an operation.
- funct3_i  input  3  operation select, RV32M encoding.
- rs1_data_i  input  nb_bits  operand A (dividend or multiplicand).
- rs2_data_i  input  nb_bits  operand B (divisor or multiplier).
- rd_add_i  input  5  destination register address.
- busy_o  output  1  high when an operation is in progress.
- done_o  output  1  one-cycle result-valid pulse, wired to register bank write enable.
- result_o  output  nb_bits  result, wired to register bank write data.
- rd_add_o  output  5  captured destination address.

Function
REQ-003 funct3_i SHALL select the operation:
- 000 MUL: low half, signed x signed.
- 001 MULH: high half, signed x signed.
- 010 MULHSU: high half, signed x unsigned.
- 011 MULHU: high half, unsigned x unsigned.
- 100 DIV: signed quotient.
- 101 DIVU: unsigned quotient.
- 110 REM: signed remainder.
- 111 REMU: unsigned remainder.
REQ-004 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-005 In IDLE, start_i=1 SHALL be accepted at the clock edge. That edge SHALL capture funct3_i, both operands and rd_add_i.
REQ-006 For a normal accept, the FSM SHALL go IDLE->CALC and load an iteration counter with nb_bits.
REQ-007 For a special-case accept (REQ-013, REQ-014), the FSM SHALL go IDLE->DONE.
REQ-008 start_i SHALL be ignored in CALC and DONE. No queueing.
REQ-009 CALC SHALL perform one iteration per cycle and decrement the counter.
- Multiply: shift-add on operand magnitudes.
- Divide: restoring division on operand magnitudes.
- When the counter reaches 0, the FSM SHALL go CALC->DONE.
REQ-010 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-011 Timing:
- busy_o SHALL be 1 in CALC and DONE.
- done_o SHALL be 1 only in DONE.
- Normal operations: done_o SHALL rise exactly nb_bits+1 edges after the accept edge, i.e. 33 for nb_bits=32.
- Special cases: done_o SHALL rise 1 edge after the accept edge.
REQ-012 Signed arithmetic:
- Multiply: the 2*nb_bits magnitude product SHALL be negated when the effective operand signs differ.
- Quotient sign SHALL be sign(A) xor sign(B).
- Remainder sign SHALL equal sign(A).
- Only funct3 000/001/100/110 SHALL treat rs2 as signed.
- Only funct3 000/001/010/100/110 SHALL treat rs1 as signed.
REQ-013 Divide by zero (B=0), for DIV and DIVU:
- Quotient SHALL be all ones.
- REM and REMU SHALL return A.
REQ-014 Signed overflow (A = most-negative, B = all ones):
- DIV SHALL return the most-negative value.
- REM SHALL return 0.
REQ-015 result_o and rd_add_o SHALL update only on entry to DONE and hold until the next DONE entry.
REQ-016 Operands captured at accept SHALL be used throughout. Input changes after accept SHALL NOT affect the result.

Reset
REQ-017 With rst_i=1 at an edge, the FSM SHALL enter IDLE regardless of state or start_i. That edge SHALL also set:
- busy_o=0, done_o=0.
- result_o=0, rd_add_o=0.
- counter=0.
REQ-018 Reset during CALC or DONE SHALL discard the operation. No done_o pulse SHALL follow until a new start is accepted after rst_i returns low.
REQ-019 An accept SHALL be possible at the first edge with rst_i=0.

Verification (nb_bits=32)
REQ-020 MUL, A=7, B=0xFFFFFFFD -> result_o=0xFFFFFFEB; done_o pulses at edge 33 after accept; busy_o high edges 1..33.
REQ-021 A=B=0xFFFFFFFF:
- MULHU -> 0xFFFFFFFE.
- MULH -> 0x00000000.
- MULHSU -> 0xFFFFFFFF.
- MUL -> 0x00000001.
REQ-022 A=0xFFFFFFF9 (-7), B=2:
- DIV -> 0xFFFFFFFD.
- REM -> 0xFFFFFFFF.
- DIVU -> 0x7FFFFFFC.
- REMU -> 0x00000001.
REQ-023 Divide-by-zero and overflow cases; each SHALL complete with done_o at edge 1:
- DIVU 5/0 -> 0xFFFFFFFF.
- REM 5/0 -> 0x00000005.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- REM of the same operands -> 0.
REQ-024 start_i held high through a full MUL -> exactly one done_o pulse per accept. The next accept occurs at the edge following DONE. rd_add_o SHALL equal the address captured at each accept.
REQ-025 rst_i=1 at edge 10 of a DIV -> busy_o=0 and result_o=0 after that edge; no done_o pulse within the following 40 cycles with start_i=0.
